// File: rtl/clock_div_pkg.sv
// Shared types and constants for the programmable clock divider.
//   state_t   : divider run state (IDLE, RUN, STOPPING)
//   MIN_DIV   : smallest divisor the divider will run with
//   clamp_div : raises divisor requests below MIN_DIV up to MIN_DIV
package clock_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < 16'(MIN_DIV)) ? 16'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/clock_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
//   en, div, load            : requester -> divider
//   clk_div, tick, busy, pend : divider -> requester
interface clock_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div;
  logic             load;
  logic             clk_div;
  logic             tick;
  logic             busy;
  logic             pend;

  modport master (output en, div, load, input clk_div, tick, busy, pend);
  modport slave  (input en, div, load, output clk_div, tick, busy, pend);
endinterface

// File: rtl/clock_div_oddext.sv
// Half-cycle extension for odd divisors.
//   clk, rst_n : source clock, async active-low reset
//   p          : posedge-registered phase from the period counter
//   odd        : active divisor is odd
//   clk_div    : p, stretched by half a clk cycle when odd
module clock_div_oddext (
  input  logic clk,
  input  logic rst_n,
  input  logic p,
  input  logic odd,
  output logic clk_div
);

  logic q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= p;
  end

  // odd only changes at a period boundary, where q is already 0, so the
  // gating never produces a glitch.
  assign clk_div = p | (q & odd);

endmodule

// File: rtl/clock_div_prog.sv
// Programmable clock divider with glitch-free divisor changes.
//   clk, rst_n : source clock, async active-low reset
//   bus        : en/div/load requests in; clk_div/tick/busy/pend out
// A divisor written with load sits in a shadow register and becomes active
// only at a period boundary (or when starting from IDLE), so every clk_div
// phase belongs to a whole period of one divisor.
//
// state    | meaning
// IDLE     | stopped, cnt=0, clk_div low
// RUN      | counting periods, en high
// STOPPING | en dropped, finishing the current period
module clock_div_prog
  import clock_div_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int RST_DIV = 2
) (
  input logic            clk,
  input logic            rst_n,
  clock_div_prog_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] cnt_q, cnt_n, cnt_inc;
  logic [WIDTH-1:0] d_act_q, d_act_n, shadow_q;
  logic             p_q, p_n, tick_q, tick_n, pend_q;
  logic             wrap, upd;

  assign wrap    = (cnt_q == d_act_q - ONE);
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    d_act_n = d_act_q;
    p_n     = p_q;
    tick_n  = 1'b0;
    upd     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        p_n   = 1'b0;
        if (bus.en) begin
          state_n = RUN;
          d_act_n = shadow_q;
          upd     = 1'b1;
          p_n     = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (wrap) begin
          cnt_n   = '0;
          d_act_n = shadow_q;
          upd     = 1'b1;
          state_n = bus.en ? RUN : IDLE;
          p_n     = bus.en;
        end else begin
          cnt_n   = cnt_inc;
          // phase and tick are registered against the count they describe
          p_n     = (cnt_inc < (d_act_q >> 1));
          tick_n  = (cnt_inc == d_act_q - ONE);
          state_n = bus.en ? RUN : STOPPING;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        p_n     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      d_act_q  <= RST_VAL;
      p_q      <= 1'b0;
      tick_q   <= 1'b0;
      shadow_q <= RST_VAL;
      pend_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      d_act_q <= d_act_n;
      p_q     <= p_n;
      tick_q  <= tick_n;
      if (bus.load) begin
        shadow_q <= WIDTH'(clamp_div(16'(bus.div)));
        pend_q   <= 1'b1;
      end else if (upd) begin
        pend_q <= 1'b0;
      end
    end
  end

  clock_div_oddext u_oddext (
    .clk     (clk),
    .rst_n   (rst_n),
    .p       (p_q),
    .odd     (d_act_q[0]),
    .clk_div (bus.clk_div)
  );

  assign bus.tick = tick_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.pend = pend_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// Bench for clock_div_prog. The reference model thinks in whole periods:
// a period of D cycles is 2*D half-cycles, clk_div is high for the first D
// of them, tick marks the last cycle, and the divisor is re-read from the
// shadow only when a period starts.
module tb_clock_div_prog;

  localparam int WIDTH   = 8;
  localparam int RST_DIV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_div_prog_if #(.WIDTH(WIDTH)) bus ();

  clock_div_prog #(.WIDTH(WIDTH), .RST_DIV(RST_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  bit m_active, m_pend;
  int m_d, m_shadow, m_pos;

  // {clk_div first half, clk_div second half, tick, busy, pend}
  logic [4:0] obs, expv;

  task automatic model_reset();
    m_active = 0; m_pend = 0; m_d = RST_DIV; m_shadow = RST_DIV; m_pos = 0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input int dv);
    bit upd;
    upd = 0;
    if (!m_active) begin
      if (en) begin m_active = 1; m_d = m_shadow; m_pos = 0; upd = 1; end
    end else if (m_pos == m_d - 1) begin
      m_d = m_shadow; m_pos = 0; upd = 1;
      if (!en) m_active = 0;
    end else begin
      m_pos++;
    end
    if (ld) begin m_shadow = (dv < 2) ? 2 : dv; m_pend = 1; end
    else if (upd) m_pend = 0;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_edge(bus.en, bus.load, int'(bus.div));
    #1;
    obs[4] = bus.clk_div; obs[2] = bus.tick; obs[1] = bus.busy; obs[0] = bus.pend;
    expv[4] = m_active && (2 * m_pos < m_d);
    expv[2] = m_active && (m_pos == m_d - 1);
    expv[1] = m_active;
    expv[0] = m_pend;
    @(negedge clk);
    #1;
    obs[3]  = bus.clk_div;
    expv[3] = m_active && (2 * m_pos + 1 < m_d);
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if ({bus.clk_div, bus.tick, bus.busy, bus.pend} !== 4'b0000)
      $display("FAIL reset_outputs got=%b want=0000", {bus.clk_div, bus.tick, bus.busy, bus.pend});
    else passes++;
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); checks++;
      if (obs !== expv) $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, obs, expv);
      else passes++;
    end
  endtask

  task automatic test_default_div2();
    int ticks;
    ticks = 0;
    bus.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(); checks++;
      if (obs !== expv) $display("FAIL div2_wave cyc=%0d got=%b want=%b", cyc, obs, expv);
      else passes++;
      ticks += int'(obs[2]);
    end
    checks++;
    if (ticks !== 6) $display("FAIL div2_tick_count got=%0d want=6", ticks);
    else passes++;
  endtask

  task automatic test_div5();
    int hi, ticks, k;
    bus.div = 8'd5; bus.load = 1'b1;
    step(); bus.load = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(); checks++;
      if (obs !== expv) $display("FAIL div5_wave cyc=%0d got=%b want=%b", cyc, obs, expv);
      else passes++;
    end
    k = 0;
    while (obs[2] !== 1'b1 && k < 20) begin step(); k++; end
    hi = 0; ticks = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      hi += int'(obs[4]) + int'(obs[3]);
      ticks += int'(obs[2]);
    end
    checks++;
    if (hi !== 5) $display("FAIL div5_high_halfcycles got=%0d want=5", hi);
    else passes++;
    checks++;
    if (ticks !== 1) $display("FAIL div5_ticks_per_period got=%0d want=1", ticks);
    else passes++;
  endtask

  task automatic test_change_4_to_7();
    int k, pend_cnt, run_len;
    logic prev;
    bit seen;
    bus.div = 8'd4; bus.load = 1'b1;
    step(); bus.load = 1'b0;
    k = 0;
    while (!(m_d == 4 && m_pos == 3) && k < 30) begin
      step(); k++; checks++;
      if (obs !== expv) $display("FAIL chg_wait cyc=%0d got=%b want=%b", cyc, obs, expv);
      else passes++;
    end
    if (k >= 30) begin checks++; $display("FAIL chg_timeout got=%0d want=<30", k); end
    step();
    bus.div = 8'd7; bus.load = 1'b1;
    pend_cnt = 0; seen = 0; run_len = 0; prev = obs[3];
    for (int i = 0; i < 30; i++) begin
      step();
      bus.load = 1'b0;
      checks++;
      if (obs !== expv) $display("FAIL chg_wave cyc=%0d got=%b want=%b", cyc, obs, expv);
      else passes++;
      if (i < 8) pend_cnt += int'(obs[0]);
      for (int h = 0; h < 2; h++) begin
        logic v;
        v = (h == 0) ? obs[4] : obs[3];
        if (v === prev) run_len++;
        else begin
          if (seen) begin
            checks++;
            if (run_len != 4 && run_len != 7)
              $display("FAIL chg_runt cyc=%0d got=%0d want=4or7", cyc, run_len);
            else passes++;
          end
          seen = 1; run_len = 1; prev = v;
        end
      end
    end
    checks++;
    if (pend_cnt !== 3) $display("FAIL chg_pend_cycles got=%0d want=3", pend_cnt);
    else passes++;
  endtask

  task automatic test_clamp();
    int k, n;
    bus.div = 8'd0; bus.load = 1'b1; step();
    bus.div = 8'd1; step();
    bus.load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(); checks++;
      if (obs !== expv) $display("FAIL clamp_wave cyc=%0d got=%b want=%b", cyc, obs, expv);
      else passes++;
    end
    k = 0;
    while (obs[2] !== 1'b1 && k < 20) begin step(); k++; end
    n = 0;
    do begin step(); n++; end while (obs[2] !== 1'b1 && n < 40);
    checks++;
    if (n !== 2) $display("FAIL clamp_period got=%0d want=2", n);
    else passes++;
    k = 0;
    while (!(m_d == 2 && m_pos == 1) && k < 10) begin step(); k++; end
    bus.div = 8'd6; bus.load = 1'b1; step();
    bus.div = 8'd9; step();
    bus.load = 1'b0;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        step(); n++; checks++;
        if (obs !== expv) $display("FAIL clamp_last_wave cyc=%0d got=%b want=%b", cyc, obs, expv);
        else passes++;
      end while (obs[2] !== 1'b1 && n < 40);
      checks++;
      if (n !== 9) $display("FAIL last_load_wins_period got=%0d want=9", n);
      else passes++;
    end
  endtask

  task automatic test_stop();
    int k, busy_cnt, hi_after;
    bus.div = 8'd6; bus.load = 1'b1; step(); bus.load = 1'b0;
    k = 0;
    while (!(m_d == 6 && m_pos == 2) && k < 40) begin step(); k++; end
    if (k >= 40) begin checks++; $display("FAIL stop_timeout got=%0d want=<40", k); end
    bus.en = 1'b0;
    busy_cnt = 0; hi_after = 0;
    for (int i = 0; i < 12; i++) begin
      step(); checks++;
      if (obs !== expv) $display("FAIL stop_wave cyc=%0d got=%b want=%b", cyc, obs, expv);
      else passes++;
      busy_cnt += int'(obs[1]);
      if (!obs[1]) hi_after += int'(obs[4]) + int'(obs[3]);
    end
    checks++;
    if (busy_cnt !== 3) $display("FAIL stop_busy_cycles got=%0d want=3", busy_cnt);
    else passes++;
    checks++;
    if (hi_after !== 0) $display("FAIL stop_clk_idle got=%0d want=0", hi_after);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.en   = ($urandom_range(0, 9) != 0);
      bus.load = ($urandom_range(0, 7) == 0);
      bus.div  = 8'($urandom_range(0, 20));
      step(); checks++;
      if (obs !== expv) $display("FAIL random_wave cyc=%0d got=%b want=%b", cyc, obs, expv);
      else passes++;
    end
    bus.load = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k, n;
    bus.en = 1'b1; bus.div = 8'd9; bus.load = 1'b1;
    step(); bus.load = 1'b0;
    k = 0;
    while (!(m_d == 9 && m_pos == 1) && k < 60) begin step(); k++; end
    checks++;
    if (bus.clk_div !== 1'b1) $display("FAIL rst_mid_precond got=%b want=1", bus.clk_div);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.clk_div, bus.tick, bus.busy, bus.pend} !== 4'b0000)
      $display("FAIL rst_mid_async got=%b want=0000", {bus.clk_div, bus.tick, bus.busy, bus.pend});
    else passes++;
    bus.en = 1'b0;
    step(); checks++;
    if (obs !== expv) $display("FAIL rst_mid_hold got=%b want=%b", obs, expv);
    else passes++;
    rst_n = 1'b1; bus.en = 1'b1;
    n = 0;
    do begin
      step(); n++; checks++;
      if (obs !== expv) $display("FAIL rst_mid_restart cyc=%0d got=%b want=%b", cyc, obs, expv);
      else passes++;
    end while (obs[2] !== 1'b1 && n < 20);
    checks++;
    if (n !== RST_DIV) $display("FAIL rst_mid_first_tick got=%0d want=%0d", n, RST_DIV);
    else passes++;
    n = 0;
    do begin step(); n++; end while (obs[2] !== 1'b1 && n < 20);
    checks++;
    if (n !== RST_DIV) $display("FAIL rst_mid_period got=%0d want=%0d", n, RST_DIV);
    else passes++;
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.div = '0;
    test_reset();
    test_default_div2();
    test_div5();
    test_change_4_to_7();
    test_clamp();
    test_stop();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
